// File: rtl/as2650_mem_responder.sv
// Memory-side responder for the AS2650 multiplexed bus: latches the address, serves
// zero-latency reads from local RAM, commits CPU writes (with protection) and accepts host preloads.
module as2650_mem_responder #(
    parameter int          ADDR_BITS = 8,
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [15:0] PROT_TOP  = 16'h0010
) (
    input  logic                 wb_clk_i,
    input  logic                 rst_n,
    input  logic [7:0]           bus_in,
    input  logic                 le_lo,
    input  logic                 le_hi,
    input  logic                 OEb,
    input  logic                 WEb,
    output logic [7:0]           bus_out,
    output logic                 bus_oe,
    input  logic                 wp_en,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [7:0]           load_data,
    output logic                 wp_fault,
    output logic                 contention,
    output logic [15:0]          rd_count,
    output logic [15:0]          wr_count
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {IDLE, READ, WRITE, COMMIT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  addr_lo_q, addr_lo_d;
    logic [7:0]  addr_hi_q, addr_hi_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        contention_q, contention_d;
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;

    logic [7:0]  mem [DEPTH];

    logic [15:0]          eff_addr;
    logic                 hit;
    logic                 rd_hit;
    logic                 protected_wr;
    logic                 commit_ok;
    logic                 load_we;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_waddr;
    logic [7:0]           mem_wdata;

    // Latch enables flow the bus straight through so the decode is valid in the latch cycle.
    assign eff_addr     = {le_hi ? bus_in : addr_hi_q, le_lo ? bus_in : addr_lo_q};
    assign hit          = (eff_addr >> ADDR_BITS) == (BASE_ADDR >> ADDR_BITS);
    assign rd_hit       = !OEb && WEb && hit && !contention_q;
    assign contention_d = contention_q | (!OEb && !WEb);

    assign protected_wr = wp_en && (wr_addr_q < PROT_TOP);
    assign commit_ok    = (state_q == COMMIT) && !contention_d && !protected_wr;
    assign wp_fault     = (state_q == COMMIT) && !contention_d && protected_wr;

    // A strobe falling in this very cycle removes ready, so the CPU always wins the RAM port.
    assign load_ready = rst_n && (state_q == IDLE) && OEb && WEb;
    assign load_we    = load_valid && load_ready;

    assign mem_we    = commit_ok || load_we;
    assign mem_waddr = commit_ok ? wr_addr_q[ADDR_BITS-1:0] : load_addr;
    assign mem_wdata = commit_ok ? wr_data_q : load_data;

    assign bus_oe     = rd_hit;
    assign bus_out    = rd_hit ? mem[eff_addr[ADDR_BITS-1:0]] : 8'h00;
    assign contention = contention_q;
    assign rd_count   = rd_count_q;
    assign wr_count   = wr_count_q;

    always_comb begin
        state_d    = state_q;
        addr_lo_d  = le_lo ? bus_in : addr_lo_q;
        addr_hi_d  = le_hi ? bus_in : addr_hi_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;

        // Once strobes have clashed, any pending write is dropped and no new access is started.
        if (contention_d) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!OEb && hit) begin
                        state_d    = READ;
                        rd_count_d = rd_count_q + 16'd1;
                    end else if (!WEb && hit) begin
                        state_d   = WRITE;
                        wr_addr_d = eff_addr;
                        wr_data_d = bus_in;
                    end
                end
                READ: begin
                    if (OEb) state_d = IDLE;
                end
                WRITE: begin
                    if (!WEb) wr_data_d = bus_in;
                    else      state_d   = COMMIT;
                end
                COMMIT: begin
                    state_d = IDLE;
                    if (commit_ok) wr_count_d = wr_count_q + 16'd1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_lo_q    <= 8'h00;
            addr_hi_q    <= 8'h00;
            wr_addr_q    <= 16'h0000;
            wr_data_q    <= 8'h00;
            contention_q <= 1'b0;
            rd_count_q   <= 16'h0000;
            wr_count_q   <= 16'h0000;
        end else begin
            state_q      <= state_d;
            addr_lo_q    <= addr_lo_d;
            addr_hi_q    <= addr_hi_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            contention_q <= contention_d;
            rd_count_q   <= rd_count_d;
            wr_count_q   <= wr_count_d;
        end
    end

    // RAM contents survive reset; writes are already gated off while reset holds the FSM in IDLE.
    always_ff @(posedge wb_clk_i) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

endmodule

// File: tb/tb_as2650_mem_responder.sv
// Directed bench for as2650_mem_responder: one base-0 instance and one based at 0x0100
// sharing the same CPU and host stimulus.
module tb_as2650_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  bus_in;
    logic        le_lo, le_hi, OEb, WEb, wp_en;
    logic        load_valid;
    logic [7:0]  load_addr, load_data;

    logic [7:0]  bus_out, bus_out2;
    logic        bus_oe, bus_oe2;
    logic        load_ready, load_ready2;
    logic        wp_fault, wp_fault2;
    logic        contention, contention2;
    logic [15:0] rd_count, rd_count2, wr_count, wr_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    as2650_mem_responder #(.ADDR_BITS(8), .BASE_ADDR(16'h0000), .PROT_TOP(16'h0010)) dut (
        .wb_clk_i(clk), .rst_n(rst_n), .bus_in(bus_in), .le_lo(le_lo), .le_hi(le_hi),
        .OEb(OEb), .WEb(WEb), .bus_out(bus_out), .bus_oe(bus_oe), .wp_en(wp_en),
        .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
        .load_data(load_data), .wp_fault(wp_fault), .contention(contention),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    as2650_mem_responder #(.ADDR_BITS(8), .BASE_ADDR(16'h0100), .PROT_TOP(16'h0010)) dut2 (
        .wb_clk_i(clk), .rst_n(rst_n), .bus_in(bus_in), .le_lo(le_lo), .le_hi(le_hi),
        .OEb(OEb), .WEb(WEb), .bus_out(bus_out2), .bus_oe(bus_oe2), .wp_en(wp_en),
        .load_valid(load_valid), .load_ready(load_ready2), .load_addr(load_addr),
        .load_data(load_data), .wp_fault(wp_fault2), .contention(contention2),
        .rd_count(rd_count2), .wr_count(wr_count2)
    );

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        load_valid = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic set_addr(input logic [15:0] a);
        @(negedge clk);
        le_hi = 1'b1; bus_in = a[15:8];
        @(negedge clk);
        le_hi = 1'b0; le_lo = 1'b1; bus_in = a[7:0];
        @(negedge clk);
        le_lo = 1'b0; bus_in = 8'h00;
    endtask

    // Ends on the negedge where the FSM sits in COMMIT.
    task automatic write_to_commit(input logic [15:0] a, input logic [7:0] d);
        set_addr(a);
        WEb = 1'b0; bus_in = d;
        @(negedge clk);
        WEb = 1'b1; bus_in = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; bus_in = 8'h00; le_lo = 1'b0; le_hi = 1'b0; OEb = 1'b1; WEb = 1'b1;
        wp_en = 1'b0; load_valid = 1'b0; load_addr = 8'h00; load_data = 8'h00;
        repeat (2) @(negedge clk);
        checks++; if (bus_oe !== 1'b0 || bus_out !== 8'h00) begin errors++;
            $display("FAIL reset_bus got oe=%0b out=%02h want oe=0 out=00", bus_oe, bus_out); end
        checks++; if (load_ready !== 1'b0 || wp_fault !== 1'b0 || contention !== 1'b0) begin errors++;
            $display("FAIL reset_flags got rdy=%0b wpf=%0b cont=%0b want 0 0 0", load_ready, wp_fault, contention); end
        checks++; if (rd_count !== 16'h0 || wr_count !== 16'h0) begin errors++;
            $display("FAIL reset_counts got rd=%0d wr=%0d want 0 0", rd_count, wr_count); end
        rst_n = 1'b1;
        #1;
        checks++; if (load_ready !== 1'b1) begin errors++;
            $display("FAIL reset_ready_after got %0b want 1", load_ready); end
        $display("test_reset done");
    endtask

    task automatic test_read_basic;
        preload(8'h05, 8'hC8);
        preload(8'h04, 8'h77);
        preload(8'h30, 8'h11);
        set_addr(16'h0005);
        OEb = 1'b0;
        #1;
        checks++; if (bus_oe !== 1'b1 || bus_out !== 8'hC8) begin errors++;
            $display("FAIL read_0005 got oe=%0b out=%02h want oe=1 out=c8", bus_oe, bus_out); end
        @(negedge clk);
        checks++; if (rd_count !== 16'd1) begin errors++;
            $display("FAIL read_count got %0d want 1", rd_count); end
        OEb = 1'b1;
        @(negedge clk);
        $display("test_read_basic done");
    endtask

    task automatic test_write_commit;
        wp_en = 1'b1;
        write_to_commit(16'h0020, 8'h3C);
        checks++; if (wp_fault !== 1'b0 || wr_count !== 16'd0) begin errors++;
            $display("FAIL wr_in_commit got wpf=%0b wr=%0d want 0 0", wp_fault, wr_count); end
        @(negedge clk);
        checks++; if (wr_count !== 16'd1) begin errors++;
            $display("FAIL wr_count got %0d want 1", wr_count); end
        OEb = 1'b0;
        #1;
        checks++; if (bus_oe !== 1'b1 || bus_out !== 8'h3C) begin errors++;
            $display("FAIL wr_readback got oe=%0b out=%02h want oe=1 out=3c", bus_oe, bus_out); end
        @(negedge clk);
        OEb = 1'b1;
        @(negedge clk);
        $display("test_write_commit done");
    endtask

    task automatic test_write_protect;
        wp_en = 1'b1;
        write_to_commit(16'h0004, 8'h55);
        checks++; if (wp_fault !== 1'b1) begin errors++;
            $display("FAIL wp_fault_pulse got %0b want 1", wp_fault); end
        @(negedge clk);
        checks++; if (wp_fault !== 1'b0 || wr_count !== 16'd1) begin errors++;
            $display("FAIL wp_after got wpf=%0b wr=%0d want 0 1", wp_fault, wr_count); end
        OEb = 1'b0;
        #1;
        checks++; if (bus_out !== 8'h77) begin errors++;
            $display("FAIL wp_mem_kept got %02h want 77", bus_out); end
        @(negedge clk);
        OEb = 1'b1;
        @(negedge clk);
        wp_en = 1'b0;
        write_to_commit(16'h0004, 8'h66);
        checks++; if (wp_fault !== 1'b0) begin errors++;
            $display("FAIL unprot_no_fault got %0b want 0", wp_fault); end
        @(negedge clk);
        checks++; if (wr_count !== 16'd2) begin errors++;
            $display("FAIL unprot_count got %0d want 2", wr_count); end
        OEb = 1'b0;
        #1;
        checks++; if (bus_out !== 8'h66) begin errors++;
            $display("FAIL unprot_readback got %02h want 66", bus_out); end
        @(negedge clk);
        checks++; if (rd_count !== 16'd4) begin errors++;
            $display("FAIL rd_count_after_writes got %0d want 4", rd_count); end
        OEb = 1'b1;
        @(negedge clk);
        $display("test_write_protect done");
    endtask

    task automatic test_base_decode;
        set_addr(16'h0005);
        OEb = 1'b0;
        #1;
        checks++; if (bus_oe2 !== 1'b0 || bus_out2 !== 8'h00 || bus_oe !== 1'b1) begin errors++;
            $display("FAIL base_miss got oe2=%0b out2=%02h oe=%0b want 0 00 1", bus_oe2, bus_out2, bus_oe); end
        @(negedge clk);
        checks++; if (rd_count2 !== 16'd0 || rd_count !== 16'd5) begin errors++;
            $display("FAIL base_miss_count got rd2=%0d rd=%0d want 0 5", rd_count2, rd_count); end
        OEb = 1'b1;
        @(negedge clk);
        set_addr(16'h0105);
        OEb = 1'b0;
        #1;
        checks++; if (bus_oe2 !== 1'b1 || bus_out2 !== 8'hC8 || bus_oe !== 1'b0) begin errors++;
            $display("FAIL base_hit got oe2=%0b out2=%02h oe=%0b want 1 c8 0", bus_oe2, bus_out2, bus_oe); end
        @(negedge clk);
        checks++; if (rd_count2 !== 16'd1 || rd_count !== 16'd5) begin errors++;
            $display("FAIL base_hit_count got rd2=%0d rd=%0d want 1 5", rd_count2, rd_count); end
        OEb = 1'b1;
        @(negedge clk);
        $display("test_base_decode done");
    endtask

    task automatic test_load_collision;
        set_addr(16'h0030);
        OEb = 1'b0; load_valid = 1'b1; load_addr = 8'h30; load_data = 8'hA5;
        #1;
        checks++; if (load_ready !== 1'b0 || bus_out !== 8'h11) begin errors++;
            $display("FAIL coll_same_cycle got rdy=%0b out=%02h want 0 11", load_ready, bus_out); end
        @(negedge clk);
        checks++; if (load_ready !== 1'b0 || bus_out !== 8'h11) begin errors++;
            $display("FAIL coll_not_taken got rdy=%0b out=%02h want 0 11", load_ready, bus_out); end
        OEb = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (load_ready !== 1'b1) begin errors++;
            $display("FAIL coll_ready_back got %0b want 1", load_ready); end
        @(negedge clk);
        load_valid = 1'b0;
        OEb = 1'b0;
        #1;
        checks++; if (bus_out !== 8'hA5) begin errors++;
            $display("FAIL coll_load_taken got %02h want a5", bus_out); end
        @(negedge clk);
        OEb = 1'b1;
        @(negedge clk);
        $display("test_load_collision done");
    endtask

    task automatic test_contention;
        OEb = 1'b0; WEb = 1'b0;
        #1;
        checks++; if (bus_oe !== 1'b0) begin errors++;
            $display("FAIL cont_oe_clash got %0b want 0", bus_oe); end
        @(negedge clk);
        checks++; if (contention !== 1'b1) begin errors++;
            $display("FAIL cont_set got %0b want 1", contention); end
        OEb = 1'b1; WEb = 1'b1;
        @(negedge clk);
        OEb = 1'b0;
        #1;
        checks++; if (bus_oe !== 1'b0 || contention !== 1'b1) begin errors++;
            $display("FAIL cont_sticky got oe=%0b cont=%0b want 0 1", bus_oe, contention); end
        @(negedge clk);
        OEb = 1'b1;
        @(negedge clk);
        $display("test_contention done");
    endtask

    task automatic test_reset_mid_write;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (contention !== 1'b0) begin errors++;
            $display("FAIL rst_clears_cont got %0b want 0", contention); end
        set_addr(16'h0030);
        WEb = 1'b0; bus_in = 8'hEE;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (rd_count !== 16'd0 || wr_count !== 16'd0) begin errors++;
            $display("FAIL rst_mid_counts got rd=%0d wr=%0d want 0 0", rd_count, wr_count); end
        @(negedge clk);
        WEb = 1'b1; bus_in = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (wr_count !== 16'd0) begin errors++;
            $display("FAIL rst_mid_no_commit got wr=%0d want 0", wr_count); end
        set_addr(16'h0030);
        OEb = 1'b0;
        #1;
        checks++; if (bus_oe !== 1'b1 || bus_out !== 8'hA5) begin errors++;
            $display("FAIL rst_mid_byte got oe=%0b out=%02h want 1 a5", bus_oe, bus_out); end
        @(negedge clk);
        checks++; if (rd_count !== 16'd1) begin errors++;
            $display("FAIL rst_mid_rd_count got %0d want 1", rd_count); end
        OEb = 1'b1;
        @(negedge clk);
        $display("test_reset_mid_write done");
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_commit();
        test_write_protect();
        test_base_decode();
        test_load_collision();
        test_contention();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
